// File: rtl/esaxi_wr_fifo.sv
// Purpose: in-order buffer for esaxi emesh write packets toward the eLink tx write channel, with drop status for debug.
// Latency: a packet pushed at edge N is presented on out_access/out_packet after edge N (1 cycle).
// Backpressure: registered wr_wait asserts at AFULL_MARGIN free entries; out_wait stalls the head; pushes into a full queue are dropped and counted.
module esaxi_wr_fifo #(
  parameter int PW           = 104,
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  output logic          out_access,
  output logic [PW-1:0] out_packet,
  input  logic          out_wait,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic [7:0]    drop_count,
  input  logic          clr_status
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MARGIN_C = (AW+1)'(AFULL_MARGIN);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          push;
  logic          pop;
  logic          drop;

  // Outputs come only from stored state, so nothing on wr_* reaches out_* combinationally.
  assign out_access = (level != '0);
  assign out_packet = mem[rd_ptr];

  // Handshake decode: a full queue still accepts when the head leaves in the same cycle.
  always_comb begin
    pop  = out_access && !out_wait;
    push = wr_access && ((level != DEPTH_C) || pop);
    drop = wr_access && !push;
  end

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + (AW+1)'(1);
    end else if (pop && !push) begin
      level_next = level - (AW+1)'(1);
    end
  end

  // Packet storage is deliberately not reset; level gates whether it is meaningful.
  always_ff @(posedge s_axi_aclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_packet;
    end
  end

  // Pointers, occupancy and the registered almost-full throttle.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      wr_wait <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level   <= level_next;
      wr_wait <= (DEPTH_C - level_next) <= MARGIN_C;
    end
  end

  // Sticky drop status; a drop coinciding with a clear is counted after the clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ovf        <= 1'b0;
      drop_count <= 8'd0;
    end else if (clr_status) begin
      ovf        <= drop;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_esaxi_wr_fifo.sv
// Bench for esaxi_wr_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_esaxi_wr_fifo;

  localparam int PW = 104;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int AFULL = 2;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn;
  logic          wr_access;
  logic [PW-1:0] wr_packet;
  logic          wr_wait;
  logic          out_access;
  logic [PW-1:0] out_packet;
  logic          out_wait;
  logic [AW:0]   level;
  logic          ovf;
  logic [7:0]    drop_count;
  logic          clr_status;

  esaxi_wr_fifo #(.PW(PW), .DEPTH(DEPTH), .AW(AW), .AFULL_MARGIN(AFULL)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .wr_access     (wr_access),
    .wr_packet     (wr_packet),
    .wr_wait       (wr_wait),
    .out_access    (out_access),
    .out_packet    (out_packet),
    .out_wait      (out_wait),
    .level         (level),
    .ovf           (ovf),
    .drop_count    (drop_count),
    .clr_status    (clr_status)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] d);
    return {32'h0000_1234, d, 32'h8000_0000 | d, 4'h0, 1'b0, 2'b10, 1'b1};
  endfunction

  // Reference model: a plain queue plus status counters.
  logic [PW-1:0] q[$];
  logic [31:0]   log_q[$];   // data field of every packet the DUT hands downstream
  bit            m_ovf;
  int            m_cnt;
  bit            m_wait;
  bit            stall;
  logic [PW-1:0] prev_pkt;
  int            mn;
  bit            mpop, mpush, mdrop;

  always @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      q.delete();
      m_ovf = 0; m_cnt = 0; m_wait = 0; stall = 0;
    end else begin
      mn = q.size();
      stall = out_access && out_wait;
      if (out_access && !out_wait) log_q.push_back(out_packet[71:40]);
      mpop  = (mn > 0) && !out_wait;
      mpush = wr_access && ((mn < DEPTH) || mpop);
      mdrop = wr_access && !mpush;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(wr_packet);
      if (clr_status) begin
        m_ovf = mdrop;
        m_cnt = mdrop ? 1 : 0;
      end else if (mdrop) begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_wait = (DEPTH - q.size()) <= AFULL;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn === 1'b1) begin
      chk("level", level, q.size());
      chk("out_access", out_access, q.size() != 0);
      if (q.size() != 0) chk("out_packet", out_packet, q[0]);
      chk("wr_wait", wr_wait, m_wait);
      chk("ovf", ovf, m_ovf);
      chk("drop_count", drop_count, m_cnt);
      if (stall) begin
        chk("stall_access", out_access, 1);
        chk("stall_packet", out_packet, prev_pkt);
      end
      prev_pkt = out_packet;
    end
  end

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic drain();
    out_wait = 0;
    wr_access = 0;
    for (int i = 0; i < 100 && level != 0; i++) tick();
    chk("drain_done", level, 0);
  endtask

  task automatic clear_status();
    clr_status = 1;
    tick();
    clr_status = 0;
  endtask

  task automatic check_log(input string nm, input int base, input int n, input int first);
    chk({nm, "_count"}, log_q.size() - base, n);
    for (int i = 0; i < n && base + i < log_q.size(); i++)
      chk({nm, "_data"}, log_q[base + i], first + i);
  endtask

  int  base;
  int  sent;
  bit  lagw;
  bit  saw;
  int  peak;

  initial begin
    s_axi_aresetn = 0;
    wr_access = 0;
    wr_packet = '0;
    out_wait = 0;
    clr_status = 0;

    // Reset state
    #23;
    chk("rst_level", level, 0);
    chk("rst_out_access", out_access, 0);
    chk("rst_wr_wait", wr_wait, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_count", drop_count, 0);
    s_axi_aresetn = 1;
    tick();

    // Single packet: visible one cycle after its push edge, then drains
    wr_access = 1;
    wr_packet = {32'h0, 32'hDEAD_BEEF, 32'h8000_0010, 4'h0, 1'b0, 2'b10, 1'b1};
    tick();
    wr_access = 0;
    chk("single_access", out_access, 1);
    chk("single_packet", out_packet, {32'h0, 32'hDEAD_BEEF, 32'h8000_0010, 4'h0, 1'b0, 2'b10, 1'b1});
    chk("single_level1", level, 1);
    chk("single_wr_wait", wr_wait, 0);
    tick();
    chk("single_level0", level, 0);
    chk("single_access0", out_access, 0);

    // 16 packets, downstream stalled, sender reacting to wr_wait one cycle late
    base = log_q.size();
    out_wait = 1; sent = 0; lagw = 0; saw = 0; peak = 0;
    for (int c = 0; c < 300 && sent < 16; c++) begin
      if (c == 40) out_wait = 0;
      wr_access = !lagw;
      if (!lagw) begin
        wr_packet = mk(sent);
        sent++;
      end
      lagw = wr_wait;
      tick();
      if (int'(level) > peak) peak = level;
      if (wr_wait) saw = 1;
    end
    chk("honour_sent", sent, 16);
    chk("honour_saw_wait", saw, 1);
    chk("honour_peak_ok", (peak == 15) || (peak == 16), 1);
    chk("honour_ovf", ovf, 0);
    drain();
    check_log("honour_order", base, 16, 0);

    // 20 packets ignoring wr_wait into a stalled queue: 4 drops
    base = log_q.size();
    out_wait = 1;
    for (int i = 0; i < 20; i++) begin
      wr_access = 1;
      wr_packet = mk(100 + i);
      tick();
    end
    wr_access = 0;
    chk("over_level", level, 16);
    chk("over_ovf", ovf, 1);
    chk("over_drops", drop_count, 4);
    drain();
    check_log("over_order", base, 16, 100);
    clear_status();
    chk("clr_ovf", ovf, 0);
    chk("clr_drops", drop_count, 0);

    // Full queue with push and pop in the same cycle
    base = log_q.size();
    out_wait = 1;
    for (int i = 0; i < 16; i++) begin
      wr_access = 1;
      wr_packet = mk(200 + i);
      tick();
    end
    out_wait = 0;
    wr_packet = mk(216);
    tick();
    out_wait = 1;
    wr_access = 0;
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", ovf, 0);
    chk("fullpp_head", out_packet[71:40], 201);
    tick();
    drain();
    check_log("fullpp_order", base, 17, 200);

    // Random wait/access traffic under the one-cycle-late wait protocol
    lagw = 0;
    for (int c = 0; c < 1000; c++) begin
      out_wait = $urandom_range(0, 1);
      wr_access = !lagw && ($urandom_range(0, 1) == 1);
      wr_packet = {$urandom(), $urandom(), $urandom(), 8'($urandom())};
      lagw = wr_wait;
      tick();
    end
    wr_access = 0;
    chk("rand_no_drop", ovf, 0);
    drain();

    // Saturating drop counter, then clear colliding with a drop
    out_wait = 1;
    wr_access = 1;
    for (int i = 0; i < 16 + 300; i++) begin
      wr_packet = mk(i);
      tick();
    end
    chk("sat_drops", drop_count, 255);
    chk("sat_ovf", ovf, 1);
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("clrdrop_count", drop_count, 1);
    chk("clrdrop_ovf", ovf, 1);

    // Asynchronous reset in the middle of a burst
    out_wait = 0;
    for (int i = 0; i < 3; i++) begin
      wr_packet = mk(500 + i);
      tick();
    end
    #2;
    s_axi_aresetn = 0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_out_access", out_access, 0);
    chk("arst_wr_wait", wr_wait, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_drops", drop_count, 0);
    wr_access = 0;
    #10;
    s_axi_aresetn = 1;
    tick();
    tick();
    chk("post_rst_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
